// File: rtl/serial_adder_sipo.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_sipo
//  Description : Bit-serial adder with serial-in/parallel-out capture. Two
//                LSB-first operand streams are summed one bit pair per beat
//                through a carry flip-flop; after WIDTH beats the parallel
//                sum and final carry are offered on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_sipo #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             start,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             frame_err
);

  localparam int              CW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   C_CNT_LAST  = CW'(WIDTH - 1);
  // Count after a start beat; a one-bit frame completes on the start beat itself.
  localparam logic [CW-1:0]   C_CNT_FIRST = CW'((WIDTH > 1) ? 1 : 0);
  localparam logic            C_ONE_BIT   = (WIDTH == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_frame_err;

  logic             w_accept;
  logic             w_cin;
  logic             w_s;
  logic             w_c_next;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_take;
  logic             w_done;
  logic             w_abort;

  assign in_ready  = (r_state != S_HOLD);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign frame_err = r_frame_err;

  // Full-adder slice; a start beat begins a new frame with a cleared carry.
  always_comb begin
    w_cin    = start ? 1'b0 : r_c;
    w_s      = a_bit ^ b_bit ^ w_cin;
    w_c_next = (a_bit & b_bit) | (w_cin & (a_bit ^ b_bit));
  end

  // The new sum bit enters at the MSB so bit 0 lands in [0] after WIDTH beats.
  generate
    if (WIDTH == 1) begin : g_sr_w1
      assign w_sr_next = w_s;
    end else begin : g_sr_wn
      assign w_sr_next = {w_s, r_sr[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus per-beat take/complete/abort strobes.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Beats without start are dropped until a frame begins.
        if (w_accept && start) begin
          w_take       = 1'b1;
          w_done       = C_ONE_BIT;
          w_state_next = C_ONE_BIT ? S_HOLD : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_accept) begin
          w_take       = 1'b1;
          w_abort      = start;
          w_done       = start ? C_ONE_BIT : (r_cnt == C_CNT_LAST);
          w_state_next = w_done ? S_HOLD : S_SHIFT;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Shift register, carry, bit counter and registered result/flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_c         <= 1'b0;
      r_sr        <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_take) begin
        r_sr <= w_sr_next;
        if (w_done) begin
          r_c   <= 1'b0;
          r_cnt <= '0;
        end else begin
          r_c   <= w_c_next;
          r_cnt <= start ? C_CNT_FIRST : (r_cnt + CW'(1));
        end
      end
      if (w_done) begin
        r_sum  <= w_sr_next;
        r_cout <= w_c_next;
      end
      r_out_valid <= (w_state_next == S_HOLD);
      r_frame_err <= w_abort;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_sipo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_sipo
//  Description : Scoreboard bench for serial_adder_sipo (WIDTH=4). Stimulus
//                pushes hand-computed {cout,sum} results; a monitor pops and
//                compares on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_sipo;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             start;
  logic             a_bit;
  logic             b_bit;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             frame_err;

  int   errors;
  int   checks;
  int   fe_count;
  int   fe_before;
  logic [WIDTH:0] exp_q[$];

  serial_adder_sipo #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .start     (start),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one pop per output handshake; also counts frame_err pulses.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (frame_err === 1'b1) fe_count++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got cout=%0b sum=%b with empty scoreboard", cout, sum);
        end else begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front();
          if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL result: got cout=%0b sum=%b expected cout=%0b sum=%b",
                     cout, sum, e[WIDTH], e[WIDTH-1:0]);
          end
        end
      end
    end
  end

  // Drive one beat and wait (bounded) until it is accepted; returns at posedge+1.
  task automatic beat(input logic a, input logic b, input logic st);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    a_bit    = a;
    b_bit    = b;
    start    = st;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL beat_timeout: in_ready stuck at %0b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Full LSB-first frame with optional idle gaps; checks out_valid latency.
  task automatic frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int gap);
    for (int i = 0; i < WIDTH; i++) begin
      beat(a[i], b[i], (i == 0));
      if (i < WIDTH - 1) begin
        chk("out_valid_early", {31'd0, out_valid}, 32'd0);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk);
          #1;
          chk("out_valid_gap", {31'd0, out_valid}, 32'd0);
        end
      end
    end
    chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    fe_count  = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    start     = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sum", {28'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    idle_cycles(1);

    // 5 + 3 = 8, back-to-back beats
    exp_q.push_back({1'b0, 4'b1000});
    frame(4'b0101, 4'b0011, 0);
    idle_cycles(2);

    // 15 + 1 = 16, two idle cycles between beats
    exp_q.push_back({1'b1, 4'b0000});
    frame(4'b1111, 4'b0001, 2);
    idle_cycles(2);

    // Back-pressure: 12 + 6 = 18 held while start beats are offered
    out_ready = 1'b0;
    exp_q.push_back({1'b1, 4'b0010});
    frame(4'b1100, 4'b0110, 0);
    in_valid = 1'b1;
    start    = 1'b1;
    a_bit    = 1'b1;
    b_bit    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_sum_cout", {27'd0, cout, sum}, {27'd0, 5'b10010});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("handshake_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    // The held start beat is taken on this edge: 1 + 1 = 2
    exp_q.push_back({1'b0, 4'b0010});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    idle_cycles(2);

    // Premature start on beat 2, then 2 + 2 = 4
    fe_before = fe_count;
    exp_q.push_back({1'b0, 4'b0100});
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b0);
    chk("pre_abort_frame_err", {31'd0, frame_err}, 32'd0);
    beat(1'b0, 1'b0, 1'b1);
    chk("abort_frame_err", {31'd0, frame_err}, 32'd1);
    beat(1'b1, 1'b1, 1'b0);
    chk("abort_err_single", {31'd0, frame_err}, 32'd0);
    chk("abort_no_early_valid", {31'd0, out_valid}, 32'd0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd1);
    idle_cycles(2);
    chk("abort_err_count", fe_count - fe_before, 32'd1);

    // Beats without start in IDLE are ignored
    fe_before = fe_count;
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    idle_cycles(3);
    chk("idle_no_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_no_frame_err", fe_count - fe_before, 32'd0);
    chk("idle_sum_kept", {27'd0, cout, sum}, {27'd0, 5'b00100});

    // Reset during beat 2, then 7 + 1 = 8
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    a_bit    = 1'b1;
    b_bit    = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    chk("mid_rst_sum", {28'd0, sum}, 32'd0);
    chk("mid_rst_cout", {31'd0, cout}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    idle_cycles(1);
    exp_q.push_back({1'b0, 4'b1000});
    frame(4'b0111, 4'b0001, 0);

    // Drain scoreboard
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle_cycles(1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
